// File: rtl/fft_unpack_if.sv
// Stream bundle between the FFT output, the frame unpacker and its downstream consumer.
// The slave modport is the unpacker's view; the master modport is the producer/consumer side.
interface fft_unpack_if #(
    parameter int LGSIZE = 11,
    parameter int WIDTH  = 16
);
    logic                 i_ce;
    logic                 i_sync;
    logic [2*WIDTH-1:0]   i_result;
    logic                 o_valid;
    logic                 i_ready;
    logic [2*WIDTH-1:0]   o_data;
    logic [LGSIZE-1:0]    o_index;
    logic                 o_last;
    logic                 o_overflow;
    logic                 o_resync;

    modport slave (
        input  i_ce, i_sync, i_result, i_ready,
        output o_valid, o_data, o_index, o_last, o_overflow, o_resync
    );

    modport master (
        output i_ce, i_sync, i_result, i_ready,
        input  o_valid, o_data, o_index, o_last, o_overflow, o_resync
    );
endinterface

// File: rtl/fft_frame_unpacker.sv
// Captures whole FFT frames into a ping-pong RAM and replays them on a valid/ready stream.
// Define FFT_UNPACK_HALF_EN to emit only bins 0..N/2-1 (real-input spectrum).
module fft_frame_unpacker #(
    parameter int LGSIZE = 11,
    parameter int WIDTH  = 16
) (
    input  logic          i_clk,
    input  logic          i_reset,
    fft_unpack_if.slave   bus
);
    localparam int N  = 1 << LGSIZE;
    localparam int DW = 2 * WIDTH;

    localparam logic [LGSIZE-1:0] BIN_LAST = {LGSIZE{1'b1}};
    localparam logic [LGSIZE-1:0] IDX_ONE  = {{(LGSIZE-1){1'b0}}, 1'b1};
`ifdef FFT_UNPACK_HALF_EN
    localparam logic [LGSIZE-1:0] OUT_LAST = {1'b0, {(LGSIZE-1){1'b1}}};
`else
    localparam logic [LGSIZE-1:0] OUT_LAST = {LGSIZE{1'b1}};
`endif

    typedef enum logic [1:0] {
        W_HUNT = 2'd0,
        W_FILL = 2'd1,
        W_DROP = 2'd2
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_PRIME  = 2'd1,
        R_STREAM = 2'd2
    } r_state_t;

    w_state_t            w_state_q, w_state_d;
    logic [LGSIZE-1:0]   wr_cnt_q, wr_cnt_d;
    logic                wr_bank_q, wr_bank_d;
    logic [1:0]          full_q, full_d;
    logic                overflow_q, overflow_d;
    logic                resync_q, resync_d;

    r_state_t            r_state_q, r_state_d;
    logic                rd_bank_q, rd_bank_d;
    logic [LGSIZE-1:0]   index_q, index_d;
    logic                last_q, last_d;
    logic [DW-1:0]       rdata_q;

    logic                we_s;
    logic [LGSIZE:0]     waddr_s;
    logic                re_s;
    logic [LGSIZE:0]     raddr_s;
    logic                release_s;
    logic                sof_s;
    logic                bank_free_s;

    logic [DW-1:0]       mem [0:2*N-1];

    // Read side: prime address 0, then fetch the next bin only on a transfer.
    always_comb begin
        r_state_d = r_state_q;
        rd_bank_d = rd_bank_q;
        index_d   = index_q;
        last_d    = last_q;
        re_s      = 1'b0;
        raddr_s   = {rd_bank_q, index_q};
        release_s = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    r_state_d = R_PRIME;
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_PRIME: begin
                re_s      = 1'b1;
                raddr_s   = {rd_bank_q, {LGSIZE{1'b0}}};
                index_d   = {LGSIZE{1'b0}};
                last_d    = (OUT_LAST == {LGSIZE{1'b0}});
                r_state_d = R_STREAM;
            end
            R_STREAM: begin
                if (bus.i_ready) begin
                    if (last_q) begin
                        // Bank handed back; the other bank may already be waiting.
                        release_s = 1'b1;
                        rd_bank_d = ~rd_bank_q;
                        last_d    = 1'b0;
                        if (full_q[~rd_bank_q]) begin
                            r_state_d = R_PRIME;
                        end else begin
                            r_state_d = R_IDLE;
                        end
                    end else begin
                        re_s    = 1'b1;
                        index_d = index_q + IDX_ONE;
                        raddr_s = {rd_bank_q, index_d};
                        last_d  = (index_d == OUT_LAST);
                    end
                end else begin
                    r_state_d = R_STREAM;
                end
            end
            default: begin
                r_state_d = R_IDLE;
            end
        endcase
    end

    // Write side: hunt for sync, fill or drop a whole frame, restart on an early sync.
    always_comb begin
        w_state_d  = w_state_q;
        wr_cnt_d   = wr_cnt_q;
        wr_bank_d  = wr_bank_q;
        overflow_d = overflow_q;
        resync_d   = resync_q;
        we_s       = 1'b0;
        waddr_s    = {wr_bank_q, wr_cnt_q};
        full_d     = full_q;
        sof_s      = bus.i_ce && bus.i_sync;
        bank_free_s = !full_q[wr_bank_q] || (release_s && (rd_bank_q == wr_bank_q));
        if (release_s) begin
            full_d[rd_bank_q] = 1'b0;
        end else begin
            full_d = full_q;
        end
        if (sof_s) begin
            if (w_state_q != W_HUNT) begin
                resync_d = 1'b1;
            end else begin
                resync_d = resync_q;
            end
            wr_cnt_d = IDX_ONE;
            if (bank_free_s) begin
                we_s      = 1'b1;
                waddr_s   = {wr_bank_q, {LGSIZE{1'b0}}};
                w_state_d = W_FILL;
            end else begin
                overflow_d = 1'b1;
                w_state_d  = W_DROP;
            end
        end else if (bus.i_ce) begin
            case (w_state_q)
                W_HUNT: begin
                    w_state_d = W_HUNT;
                end
                W_FILL: begin
                    we_s     = 1'b1;
                    wr_cnt_d = wr_cnt_q + IDX_ONE;
                    if (wr_cnt_q == BIN_LAST) begin
                        full_d[wr_bank_q] = 1'b1;
                        wr_bank_d         = ~wr_bank_q;
                        w_state_d         = W_HUNT;
                    end else begin
                        w_state_d = W_FILL;
                    end
                end
                W_DROP: begin
                    wr_cnt_d = wr_cnt_q + IDX_ONE;
                    if (wr_cnt_q == BIN_LAST) begin
                        w_state_d = W_HUNT;
                    end else begin
                        w_state_d = W_DROP;
                    end
                end
                default: begin
                    w_state_d = W_HUNT;
                end
            endcase
        end else begin
            w_state_d = w_state_q;
        end
    end

    // Control state registers for both sides.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            w_state_q  <= W_HUNT;
            wr_cnt_q   <= {LGSIZE{1'b0}};
            wr_bank_q  <= 1'b0;
            full_q     <= 2'b00;
            overflow_q <= 1'b0;
            resync_q   <= 1'b0;
            r_state_q  <= R_IDLE;
            rd_bank_q  <= 1'b0;
            index_q    <= {LGSIZE{1'b0}};
            last_q     <= 1'b0;
        end else begin
            w_state_q  <= w_state_d;
            wr_cnt_q   <= wr_cnt_d;
            wr_bank_q  <= wr_bank_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            resync_q   <= resync_d;
            r_state_q  <= r_state_d;
            rd_bank_q  <= rd_bank_d;
            index_q    <= index_d;
            last_q     <= last_d;
        end
    end

    // Ping-pong sample storage, bank select in the address MSB.
    always_ff @(posedge i_clk) begin
        if (we_s) begin
            mem[waddr_s] <= bus.i_result;
        end
    end

    // Enabled RAM output register doubles as the hold register during stalls.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rdata_q <= {DW{1'b0}};
        end else if (re_s) begin
            rdata_q <= mem[raddr_s];
        end
    end

    assign bus.o_valid    = (r_state_q == R_STREAM);
    assign bus.o_data     = rdata_q;
    assign bus.o_index    = index_q;
    assign bus.o_last     = last_q;
    assign bus.o_overflow = overflow_q;
    assign bus.o_resync   = resync_q;
endmodule

// File: tb/tb_fft_frame_unpacker.sv
// Randomized bench for fft_frame_unpacker: expected output is a queue of bins built per frame.
module tb_fft_frame_unpacker;
    localparam int LGSIZE = 11;
    localparam int WIDTH  = 16;
    localparam int N      = 1 << LGSIZE;
`ifdef FFT_UNPACK_HALF_EN
    localparam int EMIT = N / 2;
`else
    localparam int EMIT = N;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft_unpack_if #(.LGSIZE(LGSIZE), .WIDTH(WIDTH)) bus ();

    fft_frame_unpacker #(.LGSIZE(LGSIZE), .WIDTH(WIDTH)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int extra_cnt = 0;
    int ready_mode = 0;
    int unsigned rcyc = 0;
    logic [43:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Downstream ready pattern: 0 stall, 1 always, 2 one-in-three, 3 random 75%.
    initial begin
        bus.i_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: bus.i_ready = 1'b0;
                1: bus.i_ready = 1'b1;
                2: bus.i_ready = ((rcyc % 3) == 0);
                default: bus.i_ready = ($urandom_range(3) != 0);
            endcase
            rcyc++;
        end
    end

    // Output monitor: every transfer must match the head of the expected queue.
    initial begin : mon
        logic        stall;
        logic [43:0] held;
        logic [43:0] e;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
            end else begin
                if (stall)
                    check_eq("stall_hold", {bus.o_valid, bus.o_data, bus.o_index, bus.o_last}, {1'b1, held});
                if (bus.o_valid && bus.i_ready) begin
                    if (exp_q.size() == 0) begin
                        extra_cnt++;
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("xfer", {bus.o_data, bus.o_index, bus.o_last}, e);
                    end
                end
                stall = bus.o_valid && !bus.i_ready;
                held  = {bus.o_data, bus.o_index, bus.o_last};
            end
        end
    end

    task automatic put(input logic s, input logic [31:0] d);
        bus.i_ce     = 1'b1;
        bus.i_sync   = s;
        bus.i_result = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.i_ce   = 1'b0;
        bus.i_sync = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input bit keep, input bit rnd);
        for (int i = 0; i < N; i++) begin
            logic [31:0]       d;
            logic [LGSIZE-1:0] ix;
            d  = rnd ? $urandom : 32'(i);
            ix = LGSIZE'(i);
            if (keep && i < EMIT)
                exp_q.push_back({d, ix, (i == EMIT - 1)});
            put(i == 0, d);
        end
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.i_ce     = 1'b0;
        bus.i_sync   = 1'b0;
        bus.i_result = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        extra_cnt = 0;
    endtask

    task automatic drain(input string tag, input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        repeat (4) @(posedge clk);
        #1;
        check_eq({tag, "_left"}, exp_q.size(), 0);
        check_eq({tag, "_extra"}, extra_cnt, 0);
        check_eq({tag, "_idle"}, bus.o_valid, 0);
        exp_q.delete();
        extra_cnt = 0;
    endtask

    initial begin
        int k;
        int nvalid;
        bit found;
        rst          = 1'b1;
        bus.i_ce     = 1'b0;
        bus.i_sync   = 1'b0;
        bus.i_result = '0;
        do_reset();

        @(negedge clk);
        check_eq("rst_valid", bus.o_valid, 0);
        check_eq("rst_data", bus.o_data, 0);
        check_eq("rst_index", bus.o_index, 0);
        check_eq("rst_last", bus.o_last, 0);
        check_eq("rst_ovf", bus.o_overflow, 0);
        check_eq("rst_resync", bus.o_resync, 0);
        @(posedge clk);
        #1;

        // Single frame, data = index, ready held high; first valid two cycles after capture.
        ready_mode = 1;
        send_frame(1'b1, 1'b0);
        idle(0);
        @(negedge clk);
        check_eq("lat_e0", bus.o_valid, 0);
        @(negedge clk);
        check_eq("lat_e1", bus.o_valid, 0);
        @(negedge clk);
        check_eq("lat_e2", bus.o_valid, 1);
        @(posedge clk);
        #1;
        drain("single", 5000);
        check_eq("single_ovf", bus.o_overflow, 0);
        check_eq("single_resync", bus.o_resync, 0);

        // Backpressure: ready one cycle in three.
        do_reset();
        ready_mode = 2;
        send_frame(1'b1, 1'b1);
        idle(0);
        drain("bp", 9000);
        check_eq("bp_ovf", bus.o_overflow, 0);

        // Overflow: three back-to-back frames while stalled, third is dropped.
        do_reset();
        ready_mode = 0;
        send_frame(1'b1, 1'b1);
        send_frame(1'b1, 1'b1);
        send_frame(1'b0, 1'b1);
        idle(20);
        check_eq("ovf_flag", bus.o_overflow, 1);
        check_eq("ovf_stall_valid", bus.o_valid, 1);
        check_eq("ovf_stall_data", bus.o_data, exp_q[0][43:12]);
        ready_mode = 1;
        drain("ovf", 10000);
        check_eq("ovf_sticky", bus.o_overflow, 1);
        check_eq("ovf_resync", bus.o_resync, 0);

        // Resync: sync arrives at bin 500 of a frame.
        do_reset();
        ready_mode = 1;
        for (int i = 0; i < 500; i++) put(i == 0, $urandom);
        send_frame(1'b1, 1'b1);
        idle(0);
        drain("resync", 5000);
        check_eq("resync_flag", bus.o_resync, 1);
        check_eq("resync_ovf", bus.o_overflow, 0);

        // Reset mid-stream at output index 1000.
        do_reset();
        ready_mode = 1;
        send_frame(1'b1, 1'b1);
        idle(0);
        k = 0;
        found = 1'b0;
        while (!found && k < 5000) begin
            @(negedge clk);
            if (bus.o_valid && bus.o_index == 11'd1000) found = 1'b1;
            k++;
        end
        check_eq("mid_reach_1000", found, 1);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check_eq("mid_rst_valid", bus.o_valid, 0);
        check_eq("mid_rst_index", bus.o_index, 0);
        check_eq("mid_rst_last", bus.o_last, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        extra_cnt = 0;
        for (int i = 0; i < 300; i++) put(1'b0, $urandom);
        idle(0);
        nvalid = 0;
        repeat (2500) begin
            @(negedge clk);
            if (bus.o_valid) nvalid++;
        end
        check_eq("mid_quiet", nvalid, 0);
        @(posedge clk);
        #1;
        send_frame(1'b1, 1'b1);
        idle(0);
        drain("mid_after", 5000);

        // Back-to-back frames with random ready.
        do_reset();
        ready_mode = 3;
        send_frame(1'b1, 1'b1);
        send_frame(1'b1, 1'b1);
        idle(0);
        drain("b2b", 12000);
        check_eq("b2b_ovf", bus.o_overflow, 0);
        check_eq("b2b_resync", bus.o_resync, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
